// File: rtl/scu_func_int_ctrl.sv
// Per-bit enable/status state behind func_int_0, with source synchronisers and a registered irq line.
// Latency: sw pulse -> register 1 edge; source -> status p_sync_stages edges; register -> irq_o 1 edge.
// Backpressure: none; set/clear pulses are acted on in every cycle in which they are high.
module scu_func_int_ctrl #(
  parameter int                   p_int_num     = 32,
  parameter int                   p_sync_stages = 2,
  parameter logic [p_int_num-1:0] p_edge_mask   = '1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [p_int_num-1:0] int_src_i,
  input  logic [p_int_num-1:0] enable_set_i,
  input  logic [p_int_num-1:0] enable_clear_i,
  input  logic [p_int_num-1:0] sw_set_i,
  input  logic [p_int_num-1:0] sw_clr_i,
  output logic [p_int_num-1:0] enable_status_o,
  output logic [p_int_num-1:0] status_o,
  output logic [p_int_num-1:0] status_enabled_o,
  output logic                 irq_o
);

  logic [p_int_num-1:0] sync_src;
  logic [p_int_num-1:0] src_prev;
  logic [p_int_num-1:0] rise;
  logic [p_int_num-1:0] hw_set;
  logic [p_int_num-1:0] enable_q;
  logic [p_int_num-1:0] enable_nxt;
  logic [p_int_num-1:0] status_q;
  logic [p_int_num-1:0] status_nxt;
  logic                 irq_q;

  generate
    if (p_sync_stages == 0) begin : g_no_sync
      assign sync_src = int_src_i;
    end else begin : g_sync
      logic [p_int_num-1:0] sync_q [p_sync_stages];

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int s = 0; s < p_sync_stages; s++) begin
            sync_q[s] <= '0;
          end
        end else begin
          sync_q[0] <= int_src_i;
          for (int s = 1; s < p_sync_stages; s++) begin
            sync_q[s] <= sync_q[s-1];
          end
        end
      end

      assign sync_src = sync_q[p_sync_stages-1];
    end
  endgenerate

  // Edge bits capture only the rising edge; level bits re-assert while the source stays high,
  // which is why a software clear against an active level source has no effect.
  always_comb begin
    rise       = sync_src & ~src_prev;
    hw_set     = (rise & p_edge_mask) | (sync_src & ~p_edge_mask);
    status_nxt = hw_set | sw_set_i | (status_q & ~sw_clr_i);
    enable_nxt = (enable_q | enable_set_i) & ~enable_clear_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_prev <= '0;
      enable_q <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      src_prev <= sync_src;
      enable_q <= enable_nxt;
      status_q <= status_nxt;
      irq_q    <= |(status_q & enable_q);
    end
  end

  assign enable_status_o  = enable_q;
  assign status_o         = status_q;
  assign status_enabled_o = status_q & enable_q;
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_scu_func_int_ctrl.sv
// Bench for scu_func_int_ctrl: directed scenarios plus randomized traffic against a per-bit model.
module tb_scu_func_int_ctrl;

  localparam int          N    = 32;
  localparam int          SYNC = 2;
  localparam logic [31:0] MASK = 32'hFFFF_FFF7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] int_src, en_set, en_clr, sw_set, sw_clr;
  logic [N-1:0] en_stat, stat, stat_en;
  logic         irq;

  int tests = 0;
  int fails = 0;

  // reference state
  logic [N-1:0] m_en, m_st;
  logic         m_irq;
  logic [N-1:0] m_hist[$];

  scu_func_int_ctrl #(
    .p_int_num(N), .p_sync_stages(SYNC), .p_edge_mask(MASK)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .int_src_i(int_src),
    .enable_set_i(en_set), .enable_clear_i(en_clr),
    .sw_set_i(sw_set), .sw_clr_i(sw_clr),
    .enable_status_o(en_stat), .status_o(stat),
    .status_enabled_o(stat_en), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_en  = '0;
    m_st  = '0;
    m_irq = 1'b0;
    m_hist.delete();
    for (int i = 0; i <= SYNC; i++) m_hist.push_back('0);
  endtask

  // m_hist[k] is the source value seen k edges ago; the synchronised view lags SYNC edges.
  task automatic model_edge();
    logic [N-1:0] sy, pv, old_st, old_en;
    m_hist.push_front(int_src);
    sy = m_hist[SYNC];
    pv = m_hist[SYNC+1];
    void'(m_hist.pop_back());
    old_st = m_st;
    old_en = m_en;
    m_irq  = |(old_st & old_en);
    for (int i = 0; i < N; i++) begin
      if (en_clr[i])      m_en[i] = 1'b0;
      else if (en_set[i]) m_en[i] = 1'b1;
      if (MASK[i]) begin
        if ((sy[i] && !pv[i]) || sw_set[i]) m_st[i] = 1'b1;
        else if (sw_clr[i])                 m_st[i] = 1'b0;
      end else begin
        if (sy[i] || sw_set[i]) m_st[i] = 1'b1;
        else if (sw_clr[i])     m_st[i] = 1'b0;
      end
    end
  endtask

  task automatic idle();
    en_set = '0; en_clr = '0; sw_set = '0; sw_clr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      int_src = $urandom; en_set = $urandom; en_clr = $urandom;
      sw_set  = $urandom; sw_clr = $urandom;
      #2;
      tests++;
      if (en_stat !== '0 || stat !== '0 || stat_en !== '0 || irq !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: en=%h st=%h se=%h irq=%b, required all 0", en_stat, stat, stat_en, irq);
      end
    end
    @(negedge clk);
    idle();
    int_src = '0;
    rst_n   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if (en_stat !== '0 || stat !== '0 || stat_en !== '0 || irq !== 1'b0) begin
        fails++;
        $display("FAIL reset_release: en=%h st=%h se=%h irq=%b, required all 0", en_stat, stat, stat_en, irq);
      end
    end
  endtask

  task automatic test_edge_path();
    en_set = 32'h1;
    tick();
    idle();
    tests++;
    if (en_stat !== 32'h1) begin
      fails++; $display("FAIL edge_enable: en=%h required 00000001", en_stat);
    end
    int_src[0] = 1'b1;
    tick();  // E0
    tick();  // E0+1
    tests++;
    if (stat !== 32'h0) begin
      fails++; $display("FAIL edge_early: st=%h required 00000000 after E0+1", stat);
    end
    tick();  // E0+2
    tests++;
    if (stat !== 32'h1 || irq !== 1'b0) begin
      fails++; $display("FAIL edge_status: st=%h irq=%b required 00000001/0 after E0+2", stat, irq);
    end
    tick();  // E0+3
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL edge_irq: irq=%b required 1 after E0+3", irq);
    end
    sw_clr = 32'h1;
    tick();
    idle();
    tests++;
    if (stat !== 32'h0) begin
      fails++; $display("FAIL edge_clear: st=%h required 00000000", stat);
    end
    tick();
    tick();
    tests++;
    if (stat !== 32'h0 || irq !== 1'b0) begin
      fails++; $display("FAIL edge_no_reset: st=%h irq=%b required 00000000/0", stat, irq);
    end
    int_src = '0;
    en_clr  = '1;
    tick();
    idle();
  endtask

  task automatic test_level();
    int_src[3] = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (stat !== 32'h8) begin
      fails++; $display("FAIL level_set: st=%h required 00000008", stat);
    end
    sw_clr = 32'h8;
    tick();
    idle();
    tests++;
    if (stat[3] !== 1'b1) begin
      fails++; $display("FAIL level_clr_while_high: st[3]=%b required 1", stat[3]);
    end
    int_src[3] = 1'b0;
    tick(); tick(); tick();
    tests++;
    if (stat[3] !== 1'b1) begin
      fails++; $display("FAIL level_sticky: st[3]=%b required 1", stat[3]);
    end
    sw_clr = 32'h8;
    tick();
    idle();
    tests++;
    if (stat[3] !== 1'b0) begin
      fails++; $display("FAIL level_clear: st[3]=%b required 0", stat[3]);
    end
  endtask

  task automatic test_simultaneous();
    en_set = 32'hFF;
    tick();
    en_clr = 32'hFF;
    tick();
    idle();
    tests++;
    if (en_stat[7:0] !== 8'h00) begin
      fails++; $display("FAIL sim_enable: en[7:0]=%h required 00", en_stat[7:0]);
    end
    sw_set = 32'hF0;
    sw_clr = 32'hF0;
    tick();
    idle();
    tests++;
    if (stat !== 32'hF0) begin
      fails++; $display("FAIL sim_status: st=%h required 000000f0", stat);
    end
    sw_clr = '1;
    tick();
    idle();
    int_src[5] = 1'b1;
    tick(); tick();
    sw_clr = 32'h20;
    tick();
    idle();
    tests++;
    if (stat !== 32'h20) begin
      fails++; $display("FAIL sim_rise_vs_clr: st=%h required 00000020", stat);
    end
    int_src = '0;
    sw_clr  = '1;
    en_clr  = '1;
    tick();
    idle();
  endtask

  task automatic test_masking();
    sw_set = 32'hA5A5A5A5;
    tick();
    idle();
    tests++;
    if (stat !== 32'hA5A5A5A5 || stat_en !== '0) begin
      fails++; $display("FAIL mask_status: st=%h se=%h required a5a5a5a5/0", stat, stat_en);
    end
    tick();
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL mask_irq_off: irq=%b required 0", irq);
    end
    en_set = 32'h4;
    tick();
    idle();
    tests++;
    if (stat_en !== 32'h4 || irq !== 1'b0) begin
      fails++; $display("FAIL mask_enable: se=%h irq=%b required 00000004/0", stat_en, irq);
    end
    tick();
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL mask_irq_on: irq=%b required 1", irq);
    end
    en_clr = 32'h4;
    tick();
    idle();
    tests++;
    if (stat_en !== '0 || irq !== 1'b1) begin
      fails++; $display("FAIL mask_disable: se=%h irq=%b required 0/1", stat_en, irq);
    end
    tick();
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL mask_irq_fall: irq=%b required 0", irq);
    end
    sw_clr = '1;
    tick();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      int_src = int_src ^ ($urandom & $urandom & $urandom);
      en_set  = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : '0;
      en_clr  = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : '0;
      sw_set  = ($urandom_range(0, 5) == 0) ? ($urandom & $urandom) : '0;
      sw_clr  = ($urandom_range(0, 2) == 0) ? $urandom : '0;
      tick();
      tests++;
      if (en_stat !== m_en || stat !== m_st || stat_en !== (m_st & m_en) || irq !== m_irq) begin
        fails++;
        $display("FAIL random[%0d]: en=%h st=%h se=%h irq=%b required en=%h st=%h se=%h irq=%b",
                 c, en_stat, stat, stat_en, irq, m_en, m_st, m_st & m_en, m_irq);
      end
    end
    idle();
    int_src = '0;
    sw_clr  = '1;
    en_clr  = '1;
    tick(); tick(); tick(); tick();
    idle();
  endtask

  task automatic test_reset_mid();
    en_set = '1;
    sw_set = '1;
    tick();
    idle();
    tick();
    tests++;
    if (stat !== 32'hFFFFFFFF || irq !== 1'b1) begin
      fails++; $display("FAIL midrst_setup: st=%h irq=%b required ffffffff/1", stat, irq);
    end
    int_src = 32'h1;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (en_stat !== '0 || stat !== '0 || stat_en !== '0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async: en=%h st=%h se=%h irq=%b required all 0", en_stat, stat, stat_en, irq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    tests++;
    if (stat !== '0) begin
      fails++; $display("FAIL midrst_sync_lag: st=%h required 00000000", stat);
    end
    tick();
    tests++;
    if (stat !== 32'h1 || stat !== m_st) begin
      fails++; $display("FAIL midrst_capture: st=%h required 00000001", stat);
    end
    sw_clr = 32'h1;
    tick();
    idle();
    tick(); tick(); tick();
    tests++;
    if (stat !== '0 || stat !== m_st) begin
      fails++; $display("FAIL midrst_single_event: st=%h required 00000000", stat);
    end
    int_src = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    int_src = '0;
    idle();
    model_reset();
    test_reset();
    test_edge_path();
    test_level();
    test_simultaneous();
    test_masking();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scu_func_int_ctrl.md
# scu_func_int_ctrl

Functional interrupt controller for the main SCU. It holds the per-bit state behind the func_int_0 register group of the SCU register block: enable, raw status and enabled status. It consumes the write-only set/clear pulses that the register block produces and returns the enable, status and enabled-status vectors for read-back. It also synchronises up to 32 hardware interrupt sources and drives one registered interrupt line to the system interrupt controller.

## Interface
Parameters:
- p_int_num, 32: number of interrupt bits, 1..32; all vectors below are p_int_num wide.
- p_sync_stages, 2: synchroniser flops per source, 0..3; 0 means sources are already in the clk_i domain.
- p_edge_mask, all ones: per-bit source type; 1 = rising-edge (sticky), 0 = level.

Ports:
- clk_i  in  1  SCU register clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- int_src_i  in  p_int_num  hardware interrupt sources; may be asynchronous when p_sync_stages>0.
- enable_set_i  in  p_int_num  from func_int_0_enable_set; single-cycle write pulse, 1 sets the enable bit.
- enable_clear_i  in  p_int_num  from func_int_0_enable_clear; single-cycle pulse, 1 clears the enable bit.
- sw_set_i  in  p_int_num  from func_int_0_set; single-cycle pulse, 1 sets the status bit.
- sw_clr_i  in  p_int_num  from func_int_0_clr; single-cycle pulse, 1 clears the status bit.
- enable_status_o  out  p_int_num  enable register, to func_int_0_enable_status.
- status_o  out  p_int_num  raw status register, to func_int_0_status.
- status_enabled_o  out  p_int_num  status_o & enable_status_o, to func_int_0_status_enabled.
- irq_o  out  1  registered OR of status_enabled_o.

## Operation
- The register block drives set/clear inputs high for exactly one cycle per write and holds them at 0 otherwise. This block acts on every cycle in which a bit is 1.
- Synchroniser: each source passes through a chain of p_sync_stages flops, giving sync_src. All flops reset to 0.
- Edge detect: src_prev <= sync_src, reset 0. rise = sync_src & ~src_prev.
  - A source already high when reset is released produces one rise once it has passed the synchroniser.
- Enable register, per bit i:
  - enable_clear_i[i] clears the bit. Clear wins when set and clear are both 1.
  - Otherwise enable_set_i[i] sets the bit.
  - Otherwise the bit holds.
- Status register for an edge bit (p_edge_mask[i]=1):
  - Next value is 1 if rise[i] or sw_set_i[i] is 1.
  - Otherwise next value is 0 if sw_clr_i[i] is 1.
  - Otherwise the bit holds. Set (hardware or software) wins over clear in the same cycle, so no event is lost.
- Status register for a level bit (p_edge_mask[i]=0):
  - Next value is 1 if sync_src[i] or sw_set_i[i] is 1.
  - Otherwise next value is 0 if sw_clr_i[i] is 1.
  - Otherwise the bit holds. A clear issued while the source is still high has no effect. The bit is sticky after the source falls until software clears it.
- Enable gates only status_enabled_o and irq_o. Status bits are set and held whether or not the bit is enabled.
- status_enabled_o is combinational from the two registers and carries no extra state.
- irq_o <= |status_enabled_o, registered.
- Bits at p_int_num and above do not exist. The wrapper ties the unused register-block bits to 0.

## Timing
- Reset values: enable_status_o = 0, status_o = 0, status_enabled_o = 0, irq_o = 0. Synchroniser and src_prev flops are 0.
- Reset asserted mid-operation clears all state immediately and asynchronously. Pending events are lost. Release is synchronous to clk_i, which is handled by the SCU reset synchroniser.
- Source to status_o: a rising edge sampled at clock edge E0 appears in status_o after edge E0+p_sync_stages. With the default of 2, status_o is high 3 edges after first sampling.
- Software pulse to register: a set or clear pulse in cycle N changes the register at the edge ending cycle N. The new value is readable in cycle N+1.
- Register to irq_o: a change in status_o or enable_status_o in cycle N is reflected in irq_o in cycle N+1.
- Source to irq_o: p_sync_stages+2 edges with the bit enabled, which is 4 with the defaults.
- Source pulses must be high for at least p_sync_stages+1 clk_i cycles to be guaranteed captured. Shorter pulses may be missed. This is not checked.
- A new rising edge on a bit whose status is already 1 merges into the existing event. No event is counted.

## Test plan
- Reset check: hold rst_n_i=0, toggle every input -> all outputs are 0. Release reset -> all outputs stay 0 with idle inputs.
- Edge path with defaults: enable_set_i=32'h1 for one cycle, then raise int_src_i[0] at edge E0 and hold it.
  - status_o=32'h1 after edge E0+2 and irq_o=1 after edge E0+3.
  - sw_clr_i=32'h1 with the source still high -> status_o=0 in the next cycle and no re-set.
- Level path with p_edge_mask[3]=0: hold int_src_i[3]=1 and pulse sw_clr_i[3] -> status_o[3] stays 1. Drop the source, wait 3 cycles, pulse sw_clr_i[3] -> status_o[3]=0.
- Simultaneous events, each checked against the values readable the next cycle:
  - enable_set_i = enable_clear_i = 32'hFF in the same cycle -> enable_status_o[7:0]=0.
  - sw_set_i = sw_clr_i = 32'hF0 -> status_o[7:4]=1.
  - rise[5] coincident with sw_clr_i[5] -> status_o[5]=1.
- Masking: sw_set_i=32'hA5A5A5A5 with enable 0 -> status_o=32'hA5A5A5A5, status_enabled_o=0, irq_o=0.
  - Then enable_set_i=32'h00000004 -> status_enabled_o=32'h4 next cycle, irq_o=1 one cycle later.
  - Then enable_clear_i=32'h4 -> irq_o falls after 2 cycles.
- Reset mid-operation: with status_o=32'hFFFFFFFF and irq_o=1, assert rst_n_i between clock edges -> all outputs are 0 before the next edge. A source held high through release -> exactly one captured event after p_sync_stages+1 edges.
